// File: rtl/kbd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : kbd_pkg
//  Description : Shared definitions for the PS/2 keyboard port: default I/O
//                addresses, status bit positions, receiver state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package kbd_pkg;

  localparam logic [15:0] DEF_DATA_PORT = 16'h0060;
  localparam logic [15:0] DEF_STAT_PORT = 16'h0064;

  // Status byte bit positions
  localparam int STAT_NE   = 0;
  localparam int STAT_OVF  = 1;
  localparam int STAT_PERR = 2;

  // Receiver state encoding
  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

  // A frame is good when the stop bit is 1 and data+parity hold an odd count of ones
  function automatic logic frame_ok(input logic [7:0] data, input logic par, input logic stop);
    return stop & (^{data, par});
  endfunction

endpackage
`default_nettype wire

// File: rtl/kbd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : kbd_fifo
//  Description : Scan-code FIFO with push/pop/flush; head byte is shown
//                combinationally. A push while full is dropped unless a pop
//                frees a slot in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module kbd_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [7:0] din,
  output logic [7:0] head,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_do_pop;
  logic w_do_push;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CW'(DEPTH));
  assign head      = r_mem[r_rd_ptr];
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  // Pointer and occupancy bookkeeping; flush wins over any concurrent push/pop
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - CW'(1);
    end
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clock) begin
    if (w_do_push && !flush) r_mem[r_wr_ptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/kbd_port.sv
`default_nettype none
// ============================================================================
//  Module      : kbd_port
//  Description : PS/2 keyboard receiver with scan-code FIFO and a CPU I/O
//                port interface (data port pops codes, status port reads
//                flags and a write there flushes/clears).
//  Revision    : 1.0 - initial release
// ============================================================================
module kbd_port
  import kbd_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter int          TIMEOUT    = 25000,
  parameter logic [15:0] DATA_PORT  = DEF_DATA_PORT,
  parameter logic [15:0] STAT_PORT  = DEF_STAT_PORT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  input  logic [15:0] port_a,
  input  logic        pr,
  input  logic        pw,
  input  logic [7:0]  port_d,
  output logic [7:0]  port_q,
  output logic        irq
);

  localparam int TW = $clog2(TIMEOUT + 1);

  // Synchronisers and edge history
  logic r_clk_s1, r_clk_s2, r_clk_prev;
  logic r_dat_s1, r_dat_s2;
  logic w_fall;

  // Receiver state
  rx_state_t     r_state, w_state_next;
  logic [2:0]    r_bitcnt, w_bitcnt_next;
  logic [7:0]    r_shift, w_shift_next;
  logic          r_par, w_par_next;
  logic [TW-1:0] r_to_cnt;
  logic          w_timeout;
  logic          w_push;
  logic          w_perr_set;

  // CPU strobe edges and flags
  logic r_pr_d, r_pw_d;
  logic w_pop, w_flush;
  logic r_ovf, r_perr;

  // FIFO interface
  logic [7:0] w_head;
  logic       w_empty, w_full;

  logic [7:0] w_status;
  logic       w_unused_d;

  assign w_unused_d = ^port_d;

  // Two-flop synchronisers for the asynchronous PS/2 lines, idle-high on reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= ps2_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= ps2_dat;
      r_dat_s2   <= r_dat_s1;
    end
  end

  assign w_fall    = r_clk_prev & ~r_clk_s2;
  assign w_timeout = (r_state != RX_IDLE) && !w_fall && (r_to_cnt == TW'(TIMEOUT - 1));

  // Receiver registers: state, bit counter, shift register, parity, timeout
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= RX_IDLE;
      r_bitcnt <= 3'd0;
      r_shift  <= 8'h00;
      r_par    <= 1'b0;
      r_to_cnt <= '0;
    end else begin
      r_state  <= w_state_next;
      r_bitcnt <= w_bitcnt_next;
      r_shift  <= w_shift_next;
      r_par    <= w_par_next;
      if (w_fall || (r_state == RX_IDLE) || w_timeout) r_to_cnt <= '0;
      else                                             r_to_cnt <= r_to_cnt + TW'(1);
    end
  end

  // Receiver next-state logic: advances only on PS/2 falling edges
  always_comb begin
    w_state_next  = r_state;
    w_bitcnt_next = r_bitcnt;
    w_shift_next  = r_shift;
    w_par_next    = r_par;
    w_push        = 1'b0;
    w_perr_set    = 1'b0;
    if (w_fall) begin
      case (r_state)
        RX_IDLE: begin
          if (!r_dat_s2) begin
            w_state_next  = RX_DATA;
            w_bitcnt_next = 3'd0;
          end
        end
        RX_DATA: begin
          w_shift_next = {r_dat_s2, r_shift[7:1]};
          if (r_bitcnt == 3'd7) w_state_next = RX_PARITY;
          else                  w_bitcnt_next = r_bitcnt + 3'd1;
        end
        RX_PARITY: begin
          w_par_next   = r_dat_s2;
          w_state_next = RX_STOP;
        end
        RX_STOP: begin
          if (frame_ok(r_shift, r_par, r_dat_s2)) w_push     = 1'b1;
          else                                    w_perr_set = 1'b1;
          w_state_next = RX_IDLE;
        end
        default: w_state_next = RX_IDLE;
      endcase
    end else if (w_timeout) begin
      w_state_next = RX_IDLE;
    end
  end

  // CPU strobe history for rising-edge detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pr_d <= 1'b0;
      r_pw_d <= 1'b0;
    end else begin
      r_pr_d <= pr;
      r_pw_d <= pw;
    end
  end

  assign w_pop   = pr & ~r_pr_d & (port_a == DATA_PORT);
  assign w_flush = pw & ~r_pw_d & (port_a == STAT_PORT);

  // Sticky error flags; a status-port write clears them
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ovf  <= 1'b0;
      r_perr <= 1'b0;
    end else if (w_flush) begin
      r_ovf  <= 1'b0;
      r_perr <= 1'b0;
    end else begin
      if (w_perr_set) r_perr <= 1'b1;
      if (w_push && w_full && !(w_pop && !w_empty)) r_ovf <= 1'b1;
    end
  end

  kbd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .flush (w_flush),
    .din   (r_shift),
    .head  (w_head),
    .empty (w_empty),
    .full  (w_full)
  );

  // Interrupt follows the registered FIFO occupancy only
  assign irq = ~w_empty;

  // Read-data mux by port address
  always_comb begin
    w_status            = 8'h00;
    w_status[STAT_NE]   = ~w_empty;
    w_status[STAT_OVF]  = r_ovf;
    w_status[STAT_PERR] = r_perr;
    port_q              = 8'hFF;
    if (port_a == DATA_PORT)      port_q = w_empty ? 8'h00 : w_head;
    else if (port_a == STAT_PORT) port_q = w_status;
  end

endmodule
`default_nettype wire
